// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: line/prescale constants, the
// bit-counter width helper and the 2-of-3 majority used by the sampler.
// The receiver control FSM imports this package as well.
package uart_rx_pkg;

  localparam logic [5:0] MIN_PRESCALE = 6'd4;
  localparam logic       IDLE_LINE    = 1'b1;

  // Width of bit_cnt: start + DATA + parity + stop must fit, with headroom.
  function automatic int bcw(input int data);
    return $clog2(data + 4);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_timing_counter.sv
// rx_edge_bit_counter: oversampling edge counter and frame bit counter.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   enable            - frame in progress; low clears both counters
//   prescale          - clocks per bit
//   edge_cnt          - position inside the bit, 1..prescale (0 when idle)
//   bit_cnt           - 1-based bit index in the frame (0 when idle), saturating
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int BCW = bcw(8)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [5:0]     prescale,
  output logic [5:0]     edge_cnt,
  output logic [BCW-1:0] bit_cnt
);

  localparam logic [BCW-1:0] BIT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= '0;
    end else if (bit_cnt == '0) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= {{(BCW-1){1'b0}}, 1'b1};
    end else if (edge_cnt >= prescale) begin
      // >= rather than == so a prescale lowered mid-bit still wraps at once.
      edge_cnt <= 6'd1;
      if (bit_cnt != BIT_MAX) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/uart_rx_timing.sv
// uart_rx_timing: timing and sampling front-end of the UART receiver.
// Ports:
//   CLK, RST          - oversampling clock, synchronous active-high reset
//   RX_IN             - serial line, already synchronised to CLK
//   enable            - from the FSM, high for the whole frame
//   data_sample_en    - from the FSM, gates sampling
//   prescale          - clocks per bit (legal: even, 4..62)
//   edge_cnt, bit_cnt - counters used by the FSM
//   sampled_bit       - majority-voted bit value, held between updates
//   sample_valid      - one-cycle pulse when sampled_bit updates
module uart_rx_timing
  import uart_rx_pkg::*;
#(
  parameter int DATA = 8,
  parameter int BCW  = bcw(DATA)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           RX_IN,
  input  logic           enable,
  input  logic           data_sample_en,
  input  logic [5:0]     prescale,
  output logic [5:0]     edge_cnt,
  output logic [BCW-1:0] bit_cnt,
  output logic           sampled_bit,
  output logic           sample_valid
);

  logic [5:0] half;
  logic       legal;
  logic       sample_on;
  logic       cap0, cap1, cap2, cap_single;
  logic       s0, s1;

  rx_edge_bit_counter #(.BCW(BCW)) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .enable   (enable),
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  assign half       = {1'b0, prescale[5:1]};
  assign legal      = (prescale >= MIN_PRESCALE);
  assign sample_on  = enable && data_sample_en;
  assign cap0       = sample_on && legal && (edge_cnt == half - 6'd1);
  assign cap1       = sample_on && legal && (edge_cnt == half);
  assign cap2       = sample_on && legal && (edge_cnt == half + 6'd1);
  assign cap_single = sample_on && !legal && (edge_cnt == 6'd1);

  // The third sample is voted straight from RX_IN on its capture edge, so it
  // never needs its own register; the result appears one cycle after it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0           <= IDLE_LINE;
      s1           <= IDLE_LINE;
      sampled_bit  <= IDLE_LINE;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (cap0) begin
        s0 <= RX_IN;
      end
      if (cap1) begin
        s1 <= RX_IN;
      end
      if (cap2) begin
        sampled_bit  <= maj3(s0, s1, RX_IN);
        sample_valid <= 1'b1;
      end
      if (cap_single) begin
        sampled_bit  <= RX_IN;
        sample_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_timing.sv
// Self-checking bench for uart_rx_timing. Inputs are driven and outputs are
// observed on the falling clock edge. Expected samples go into a scoreboard
// queue; a monitor pops one on every sample_valid pulse.
module tb_uart_rx_timing;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       enable;
  logic       data_sample_en;
  logic [5:0] prescale;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  typedef struct {
    logic b;
    int   e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  uart_rx_timing #(.DATA(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .RX_IN          (RX_IN),
    .enable         (enable),
    .data_sample_en (data_sample_en),
    .prescale       (prescale),
    .edge_cnt       (edge_cnt),
    .bit_cnt        (bit_cnt),
    .sampled_bit    (sampled_bit),
    .sample_valid   (sample_valid)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_sample: sample_valid with empty scoreboard, got bit %0d edge %0d (t=%0t)",
                 sampled_bit, edge_cnt, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sample_bit", int'(sampled_bit), int'(e.b));
        check("sample_edge", int'(edge_cnt), e.e);
      end
    end
  end

  // Drives a frame with bits[0] first; each bit lasts ps cycles. An optional
  // one-cycle inversion is applied at edge gedge of bit gbit.
  task automatic run_frame(input logic [5:0] ps, input logic [15:0] bits, input int nbits,
                           input logic [15:0] exp_bits, input int exp_edge,
                           input int gbit, input int gedge);
    for (int i = 0; i < nbits; i++) begin
      sb.push_back('{b: exp_bits[i], e: exp_edge});
    end
    prescale       = ps;
    data_sample_en = 1'b1;
    enable         = 1'b1;
    RX_IN          = bits[0];
    for (int j = 1; j <= nbits * int'(ps); j++) begin
      int idx;
      int e;
      @(negedge CLK);
      idx   = (j - 1) / int'(ps);
      e     = (j - 1) % int'(ps) + 1;
      RX_IN = bits[idx] ^ ((idx == gbit && e == gedge) ? 1'b1 : 1'b0);
    end
    @(negedge CLK);
    enable         = 1'b0;
    data_sample_en = 1'b0;
    RX_IN          = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int hits;
    RST            = 1'b1;
    RX_IN          = 1'b1;
    enable         = 1'b0;
    data_sample_en = 1'b0;
    prescale       = 6'd8;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_edge", int'(edge_cnt), 0);
    check("rst_bit", int'(bit_cnt), 0);
    check("rst_sampled", int'(sampled_bit), 1);
    check("rst_valid", int'(sample_valid), 0);
    RST = 1'b0;
    @(negedge CLK);

    // prescale 8, enable for 88 cycles, no sampling
    prescale = 6'd8;
    enable   = 1'b1;
    hits     = 0;
    for (int i = 0; i < 88; i++) begin
      @(negedge CLK);
      check("p8_edge", int'(edge_cnt), (i % 8) + 1);
      check("p8_bit", int'(bit_cnt), i / 8 + 1);
      if (edge_cnt == prescale) hits++;
    end
    check("p8_wrap_hits", hits, 11);
    enable = 1'b0;
    repeat (2) @(negedge CLK);

    // prescale 16, frame 0xA5: start, A5 LSB first, stop
    run_frame(6'd16, 16'b1_1010_0101_0, 10, 16'b11_0100_1010, 10, -1, 0);

    // prescale 8, glitch at edge 4 of a '1' bit is voted away
    run_frame(6'd8, 16'b10, 2, 16'b10, 6, 1, 4);

    // prescale 4: pulse lands at edge 4, before the bit advances
    run_frame(6'd4, 16'b0110, 4, 16'b0110, 4, -1, 0);

    // prescale 2 (illegal): single sample at edge 1, pulse at edge 2
    run_frame(6'd2, 16'b101, 3, 16'b101, 2, -1, 0);

    // Abort at bit 5, edge 3, then re-enable
    prescale       = 6'd8;
    data_sample_en = 1'b1;
    RX_IN          = 1'b0;
    enable         = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back('{b: 1'b0, e: 6});
    repeat (35) @(negedge CLK);
    check("abort_pre_edge", int'(edge_cnt), 3);
    check("abort_pre_bit", int'(bit_cnt), 5);
    enable = 1'b0;
    @(negedge CLK);
    check("abort_edge", int'(edge_cnt), 0);
    check("abort_bit", int'(bit_cnt), 0);
    check("abort_valid", int'(sample_valid), 0);
    enable = 1'b1;
    @(negedge CLK);
    check("reen_edge", int'(edge_cnt), 1);
    check("reen_bit", int'(bit_cnt), 1);
    enable = 1'b0;
    @(negedge CLK);

    // Enable dropped on the third-capture cycle: no pulse
    RX_IN  = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge CLK);
    check("drop_s2_edge", int'(edge_cnt), 5);
    enable = 1'b0;
    @(negedge CLK);
    check("drop_s2_valid", int'(sample_valid), 0);
    check("drop_s2_hold", int'(sampled_bit), 0);
    data_sample_en = 1'b0;
    @(negedge CLK);

    // prescale lowered 16 -> 8 at edge 12
    prescale = 6'd16;
    enable   = 1'b1;
    repeat (12) @(negedge CLK);
    check("ps_chg_pre_edge", int'(edge_cnt), 12);
    prescale = 6'd8;
    @(negedge CLK);
    check("ps_chg_edge", int'(edge_cnt), 1);
    check("ps_chg_bit", int'(bit_cnt), 2);
    @(negedge CLK);
    check("ps_chg_edge2", int'(edge_cnt), 2);
    enable = 1'b0;
    repeat (2) @(negedge CLK);

    // RST mid-frame with enable held high
    prescale       = 6'd8;
    data_sample_en = 1'b1;
    RX_IN          = 1'b0;
    enable         = 1'b1;
    sb.push_back('{b: 1'b0, e: 6});
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_edge", int'(edge_cnt), 0);
    check("mid_rst_bit", int'(bit_cnt), 0);
    check("mid_rst_sampled", int'(sampled_bit), 1);
    check("mid_rst_valid", int'(sample_valid), 0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_edge", int'(edge_cnt), 1);
    check("post_rst_bit", int'(bit_cnt), 1);
    enable         = 1'b0;
    data_sample_en = 1'b0;
    repeat (3) @(negedge CLK);

    check("scoreboard_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
